mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor of the team's 16-bit single-cycle MIPS core, for the next CPU top level.
- Executes the same six-instruction subset (R-type ADD/SUB/AND/OR/SLT, LW, SW, BEQ, ADDI, J) over a generic data width and register count.
- Instruction and data memories are reached through separate req/ready handshake ports, so slow memories stall the core instead of being combinational.
- Adds sign-extended immediates, signed SLT, hardwired r0 and a halt-on-illegal-instruction trap.

Parameters:
- DW, 16, datapath/register/data-memory word width (>=16).
- AW, 16, PC and memory word-address width (<=DW).
- NREG, 16, register count, power of 2 (2..32); RA = clog2(NREG).
- RESET_PC, 0, PC value loaded by reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch word address (= pc).
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  AW  data word address (ALU result, low AW bits).
- dmem_wdata  out  DW  store data (rt value).
- dmem_ready  in  1  access complete / dmem_rdata valid.
- dmem_rdata  in  DW  load data.
- pc  out  AW  current PC.
- rout  out  DW  debug copy of register NREG-1.
- halted  out  1  core stopped on illegal instruction.

Behaviour:
- Reset (async, asynchronous active-high on reset; clocked on clk):
  - pc=RESET_PC; all registers 0; state FETCH; imem_req=0, dmem_req=0, dmem_we=0, halted=0, rout=0.
  - imem_req rises on the first clk edge after reset falls.
  - All req/we/addr/wdata outputs are registered.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1, imem_addr=pc held stable until imem_ready; on imem_ready, latch IR, deassert imem_req, go DECODE. Zero-wait memory costs 1 cycle.
  - DECODE: read rs=IR[21+RA-1:21], rt=IR[16+RA-1:16]; latch imm=sign-extend(IR[15:0]) to DW. Illegal opcode or R-type funct -> HALT.
  - EXEC (ALU):
    - R: funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0) -> WB.
    - LW/SW (100011/101011): addr=rs+imm -> MEM.
    - ADDI (010000): rs+imm -> WB.
    - BEQ (001000): if rs==rt then pc=pc+1+imm, else pc=pc+1 -> FETCH.
    - J (000010): pc=IR[AW-1:0] -> FETCH.
  - MEM: dmem_req=1 with addr/we/wdata stable until dmem_ready.
    - SW: on ready -> FETCH with pc+1.
    - LW: on ready, latch dmem_rdata -> WB.
  - WB: write rd=IR[11+RA-1:11] (R-type) or rt (LW/ADDI); pc=pc+1 -> FETCH.
  - HALT: absorbing; pc frozen, no requests, halted=1; only reset exits.
- Latency with zero-wait memories, in cycles: R/ADDI 4, LW 5, SW 4, BEQ/J 3. Each wait cycle adds 1.
- Arithmetic: add/sub/pc arithmetic wrap modulo 2^DW / 2^AW, no overflow trap; a branch target past 2^AW-1 wraps.
- r0 reads 0 always; writes to r0 discarded.
- ready asserted while the corresponding req is low is ignored.
- Reset mid-access (req high, ready pending): req drops immediately; the stale ready is ignored; the interrupted SW does not count as committed by the core.
- rout updates the cycle after a WB to register NREG-1.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r15,r1,r2, zero-wait -> rout=2 after 12 cycles; SUB gives 8; SLT r15,r2,r1 -> 1 (signed).
- SW r1 to addr 4 with dmem_ready delayed 3 cycles, then LW r15 from 4 -> dmem_req/addr/wdata stable during wait, rout=5, SW takes 7 cycles.
- BEQ equal with imm=-2 at pc=10 -> pc=9; BEQ not equal -> pc=11; each 3 cycles.
- J 0x0020 -> pc=0x20, imem_addr=0x20 next FETCH; ADDI r0,r0,7 then ADD r15,r0,r0 -> rout=0.
- Opcode 111111 -> halted=1 after DECODE, pc frozen, no req for 20 cycles; reset clears halted and pc=RESET_PC.
- Assert reset while imem_req=1 and imem_ready=0 -> req low asynchronously, registers 0; with DW=32, NREG=32, ADDI r31,r0,-1 -> rout=0xFFFFFFFF.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core (ADD/SUB/AND/OR/SLT, LW, SW, BEQ, ADDI, J).
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB]; illegal instructions trap to HALT.
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   imem_req/addr/ready/rdata  instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/ready/rdata  data access handshake
//   pc                      current PC
//   rout                    registered copy of register NREG-1
//   halted                  core stopped on an illegal instruction
module mips_multicycle_core #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int NREG     = 16,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] rout,
  output logic          halted
);
  localparam int RA = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_BEQ   = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, imem_addr_q, imem_addr_d, dmem_addr_q, dmem_addr_d;
  logic [31:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [DW-1:0] dmem_wdata_q, dmem_wdata_d, rout_q, rout_d;
  logic          imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [DW-1:0] rf_q [NREG];

  logic [5:0]    opcode, funct;
  logic [RA-1:0] rs_idx, rt_idx, rd_idx, rf_waddr;
  logic [DW-1:0] alu_b, alu_res, rf_wdata;
  logic [AW-1:0] pc_plus1;
  logic          imem_fire, dmem_fire, is_legal, rf_we;
  logic          unused_ir;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs_idx    = ir_q[21 +: RA];
  assign rt_idx    = ir_q[16 +: RA];
  assign rd_idx    = ir_q[11 +: RA];
  assign pc_plus1  = pc_q + AW'(1);
  // A ready seen while our own request is low is not ours: ignore it.
  assign imem_fire = imem_req_q && imem_ready;
  assign dmem_fire = dmem_req_q && dmem_ready;
  assign rf_waddr  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
  assign rf_wdata  = (opcode == OP_LW) ? mdr_q : alu_q;
  // Shamt and the register-index bits above RA are don't-care.
  assign unused_ir = ^ir_q;

  always_comb begin
    case (opcode)
      OP_RTYPE: is_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT);
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_b   = (opcode == OP_RTYPE) ? b_q : imm_q;
    alu_res = a_q + alu_b;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? DW'(1) : '0;
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_fire) state_d = S_DECODE;
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ, OP_J:      state_d = S_FETCH;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEM:    if (dmem_fire) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    imm_d        = imm_q;
    alu_d        = alu_q;
    mdr_d        = mdr_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;
    case (state_q)
      S_FETCH: if (imem_fire) ir_d = imem_rdata;
      S_DECODE: begin
        a_d   = rf_q[rs_idx];
        b_d   = rf_q[rt_idx];
        imm_d = DW'($signed(ir_q[15:0]));
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (opcode == OP_BEQ) pc_d = (a_q == b_q) ? pc_plus1 + imm_q[AW-1:0] : pc_plus1;
        else if (opcode == OP_J) pc_d = ir_q[AW-1:0];
        // Address/data are captured once on MEM entry and then held for the whole wait.
        if (state_d == S_MEM) begin
          dmem_addr_d  = alu_res[AW-1:0];
          dmem_wdata_d = b_q;
        end
      end
      S_MEM: begin
        if (dmem_fire) begin
          if (opcode == OP_LW) mdr_d = dmem_rdata;
          else                 pc_d  = pc_plus1;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_d  = pc_plus1;
      end
      default: ;
    endcase
    // Requests are decided from the next state so they are registered yet
    // present during the first cycle of FETCH/MEM.
    imem_req_d  = (state_d == S_FETCH);
    imem_addr_d = pc_d;
    dmem_req_d  = (state_d == S_MEM);
    dmem_we_d   = (state_d == S_MEM) && (opcode == OP_SW);
    rout_d      = rf_q[NREG-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= AW'(RESET_PC);
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      alu_q        <= '0;
      mdr_q        <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= AW'(RESET_PC);
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rout_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      alu_q        <= alu_d;
      mdr_q        <= mdr_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rout_q       <= rout_d;
    end
  end

  // Register file; r0 is never written so it always reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign rout       = rout_q;
  assign halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed testbench for mips_multicycle_core: default 16-bit core with
// instruction/data memory models (programmable wait states) plus a 32-bit,
// 32-register instance that keeps executing ADDI r31,r0,-1.
`timescale 1ns/1ps
module tb_mips_multicycle_core;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b010000;
  localparam logic [5:0] OP_BEQ  = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
  logic [15:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc, rout;
  logic [31:0] imem_rdata;

  logic        w_imem_req, w_imem_ready, w_dmem_req, w_dmem_we, w_dmem_ready, w_halted;
  logic [15:0] w_imem_addr, w_dmem_addr, w_pc;
  logic [31:0] w_imem_rdata, w_dmem_wdata, w_dmem_rdata, w_rout;

  int passed = 0;
  int total  = 0;
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;
  logic [31:0] imem [256];
  logic [15:0] dmem [256];

  assign imem_ready = imem_req && (icnt >= imem_wait);
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always @(posedge clk) begin
    icnt <= (!imem_req || imem_ready) ? 0 : icnt + 1;
    dcnt <= (!dmem_req || dmem_ready) ? 0 : dcnt + 1;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
  end

  assign w_imem_ready = 1'b1;
  assign w_imem_rdata = 32'h401F_FFFF;  // ADDI r31,r0,-1
  assign w_dmem_ready = 1'b0;
  assign w_dmem_rdata = 32'h0;

  mips_multicycle_core u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .rout(rout), .halted(halted)
  );

  mips_multicycle_core #(.DW(32), .AW(16), .NREG(32), .RESET_PC(0)) u_dut32 (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready), .imem_rdata(w_imem_rdata),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata),
    .dmem_ready(w_dmem_ready), .dmem_rdata(w_dmem_rdata),
    .pc(w_pc), .rout(w_rout), .halted(w_halted)
  );

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'b000010, target};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = ILLEGAL;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs until one negedge past the next fetch handshake; cyc equals the
  // latency of the instruction that was executing when called.
  task automatic advance(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (seen) break;
      if (imem_req && imem_ready) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int c;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({imem_req, dmem_req, dmem_we, halted} !== 4'b0000)
      $display("FAIL reset_ctrl: req/dreq/we/halted=%b required 0000", {imem_req, dmem_req, dmem_we, halted});
    else passed++;
    total++;
    if (pc !== 16'h0 || rout !== 16'h0 || w_rout !== 32'h0)
      $display("FAIL reset_state: pc=%h rout=%h w_rout=%h required 0", pc, rout, w_rout);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0) $display("FAIL req_after_release: imem_req=%b required 0", imem_req);
    else passed++;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0)
      $display("FAIL first_fetch: imem_req=%b addr=%h required 1/0000", imem_req, imem_addr);
    else passed++;
    advance(c);
  endtask

  task automatic test_alu();
    int c;
    logic [15:0] exp_rout [9];
    exp_rout = '{16'd0, 16'd0, 16'd2, 16'd8, 16'd1, 16'd0, 16'd0, 16'd4, 16'd7};
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    imem[1] = enc_i(OP_ADDI, 0, 2, 16'hFFFD);
    imem[2] = enc_r(1, 2, 15, FN_ADD);
    imem[3] = enc_r(1, 2, 15, FN_SUB);
    imem[4] = enc_r(2, 1, 15, FN_SLT);
    imem[5] = enc_r(1, 2, 15, FN_SLT);
    imem[6] = enc_i(OP_ADDI, 0, 3, 16'd6);
    imem[7] = enc_r(1, 3, 15, FN_AND);
    imem[8] = enc_r(1, 3, 15, FN_OR);
    imem_wait = 0;
    dmem_wait = 0;
    apply_reset();
    advance(c);
    for (int i = 0; i < 9; i++) begin
      advance(c);
      total++;
      if (c !== 4) $display("FAIL alu_latency[%0d]: cycles=%0d required 4", i, c);
      else passed++;
      total++;
      if (rout !== exp_rout[i] || pc !== 16'(i + 1))
        $display("FAIL alu_result[%0d]: rout=%h pc=%h required %h/%h", i, rout, pc, exp_rout[i], 16'(i + 1));
      else passed++;
    end
  endtask

  task automatic test_mem();
    int c;
    int nreq;
    bit seen;
    bit stable;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    imem[1] = enc_i(OP_SW, 0, 1, 16'd4);
    imem[2] = enc_i(OP_LW, 0, 15, 16'd4);
    imem[3] = enc_i(OP_ADDI, 0, 4, 16'd1);
    imem_wait = 0;
    dmem_wait = 3;
    apply_reset();
    advance(c);
    advance(c);
    c = 0; nreq = 0; seen = 1'b0; stable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      c++;
      if (seen) break;
      if (dmem_req) begin
        nreq++;
        if (dmem_addr !== 16'd4 || dmem_wdata !== 16'd5 || dmem_we !== 1'b1) stable = 1'b0;
      end
      if (imem_req && imem_ready) seen = 1'b1;
    end
    total++;
    if (c !== 7) $display("FAIL sw_latency: cycles=%0d required 7", c);
    else passed++;
    total++;
    if (nreq !== 4 || !stable) $display("FAIL sw_req_hold: req_cycles=%0d stable=%b required 4/1", nreq, stable);
    else passed++;
    total++;
    if (dmem[4] !== 16'd5) $display("FAIL sw_data: mem[4]=%h required 0005", dmem[4]);
    else passed++;
    advance(c);
    total++;
    if (c !== 8) $display("FAIL lw_latency: cycles=%0d required 8", c);
    else passed++;
    total++;
    if (rout !== 16'd5 || dmem_req !== 1'b0) $display("FAIL lw_result: rout=%h dmem_req=%b required 0005/0", rout, dmem_req);
    else passed++;
    dmem_wait = 0;
  endtask

  task automatic test_branch_jump();
    int c;
    int exp_lat [8];
    logic [15:0] exp_pc [8];
    exp_lat = '{4, 3, 3, 4, 3, 3, 4, 4};
    exp_pc  = '{16'h01, 16'h0A, 16'h09, 16'h0A, 16'h0B, 16'h20, 16'h21, 16'h22};
    clear_imem();
    imem[0]     = enc_i(OP_ADDI, 0, 15, 16'd9);
    imem[1]     = enc_j(26'd10);
    imem[9]     = enc_i(OP_ADDI, 0, 2, 16'd7);
    imem[10]    = enc_i(OP_BEQ, 2, 0, 16'hFFFE);
    imem[11]    = enc_j(26'h20);
    imem[8'h20] = enc_i(OP_ADDI, 0, 0, 16'd7);
    imem[8'h21] = enc_r(0, 0, 15, FN_ADD);
    apply_reset();
    advance(c);
    for (int i = 0; i < 8; i++) begin
      advance(c);
      total++;
      if (c !== exp_lat[i] || pc !== exp_pc[i])
        $display("FAIL flow[%0d]: cycles=%0d pc=%h required %0d/%h", i, c, pc, exp_lat[i], exp_pc[i]);
      else passed++;
      if (i == 1) begin
        total++;
        if (rout !== 16'd9) $display("FAIL addi_r15: rout=%h required 0009", rout);
        else passed++;
      end
      if (i == 5) begin
        total++;
        if (imem_addr !== 16'h20) $display("FAIL jump_fetch_addr: imem_addr=%h required 0020", imem_addr);
        else passed++;
      end
    end
    total++;
    if (rout !== 16'd0) $display("FAIL r0_hardwired: rout=%h required 0000", rout);
    else passed++;
  endtask

  task automatic test_halt();
    int c;
    bit quiet;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd1);
    apply_reset();
    advance(c);
    advance(c);
    total++;
    if (halted !== 1'b0 || pc !== 16'd1) $display("FAIL pre_halt: halted=%b pc=%h required 0/0001", halted, pc);
    else passed++;
    @(negedge clk);
    total++;
    if (halted !== 1'b1) $display("FAIL halt_entry: halted=%b required 1", halted);
    else passed++;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req || dmem_req || pc !== 16'd1 || !halted) quiet = 1'b0;
    end
    total++;
    if (!quiet) $display("FAIL halt_frozen: quiet=%b pc=%h required 1/0001", quiet, pc);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0 || pc !== 16'd0) $display("FAIL halt_reset: halted=%b pc=%h required 0/0000", halted, pc);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c;
    bit got;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 15, 16'd3);
    imem[1] = enc_i(OP_ADDI, 0, 1, 16'd1);
    imem[2] = enc_i(OP_ADDI, 0, 2, 16'd2);
    imem_wait = 0;
    apply_reset();
    advance(c);
    advance(c);
    total++;
    if (rout !== 16'd3) $display("FAIL mid_pre_rout: rout=%h required 0003", rout);
    else passed++;
    imem_wait = 5;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req) begin got = 1'b1; break; end
    end
    total++;
    if (!got || imem_ready !== 1'b0) $display("FAIL mid_pending: req_seen=%b ready=%b required 1/0", got, imem_ready);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || rout !== 16'd0 || pc !== 16'd0 || w_rout !== 32'h0)
      $display("FAIL mid_async_reset: req=%b rout=%h pc=%h w_rout=%h required 0", imem_req, rout, pc, w_rout);
    else passed++;
    @(negedge clk);
    imem_wait = 0;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (w_rout !== 32'hFFFF_FFFF || w_halted !== 1'b0)
      $display("FAIL wide_addi: w_rout=%h halted=%b required ffffffff/0", w_rout, w_halted);
    else passed++;
    total++;
    if (w_pc !== 16'd2 || w_imem_addr !== 16'd2 || w_imem_req !== 1'b0)
      $display("FAIL wide_pc: pc=%h addr=%h req=%b required 0002/0002/0", w_pc, w_imem_addr, w_imem_req);
    else passed++;
    total++;
    if ({w_dmem_req, w_dmem_we} !== 2'b00 || w_dmem_addr !== 16'h0 || w_dmem_wdata !== 32'h0)
      $display("FAIL wide_dmem_idle: req=%b we=%b addr=%h wdata=%h required 0", w_dmem_req, w_dmem_we, w_dmem_addr, w_dmem_wdata);
    else passed++;
  endtask

  initial begin
    clear_imem();
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
